// File: rtl/check_pkt_meta_joiner.sv
// rtl/check_pkt_meta_joiner.sv - joins packet flits with their metadata word into one stream
// Framing checks (orphan discard, truncation close, error/drop stats) enabled by JOINER_FRAMING_CHECK_EN.
module check_pkt_meta_joiner #(
  parameter int DWIDTH = 512,
  parameter int EWIDTH = 6,
  parameter int MWIDTH = 64
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DWIDTH-1:0] in_pkt_data,
  input  logic              in_pkt_valid,
  input  logic              in_pkt_sop,
  input  logic              in_pkt_eop,
  input  logic [EWIDTH-1:0] in_pkt_empty,
  output logic              in_pkt_ready,
  input  logic [MWIDTH-1:0] in_meta_data,
  input  logic              in_meta_valid,
  output logic              in_meta_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [EWIDTH-1:0] out_empty,
  output logic [MWIDTH-1:0] out_meta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       stats_pkt,
  output logic [31:0]       stats_err,
  output logic [31:0]       stats_drop_flit
);

  typedef enum logic [1:0] {IDLE, STREAM, CLOSE} state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [EWIDTH-1:0] out_empty_q, out_empty_d;
  logic [MWIDTH-1:0] out_meta_q, out_meta_d;
  logic              out_valid_q, out_valid_d;
  logic              orphan_q, orphan_d;
  logic [31:0]       stats_pkt_q, stats_pkt_d;
  logic [31:0]       stats_err_q, stats_err_d;
  logic [31:0]       stats_drop_q, stats_drop_d;
  logic              ld;
  logic              pkt_rdy, meta_rdy;

  always_comb begin
    ld           = !out_valid_q || out_ready;
    state_d      = state_q;
    pkt_rdy      = 1'b0;
    meta_rdy     = 1'b0;
    out_data_d   = out_data_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_empty_d  = out_empty_q;
    out_meta_d   = out_meta_q;
    out_valid_d  = out_valid_q && !out_ready;
    orphan_d     = orphan_q;
    stats_pkt_d  = stats_pkt_q + {31'd0, out_valid_q && out_ready && out_eop_q};
    stats_err_d  = stats_err_q;
    stats_drop_d = stats_drop_q;

    case (state_q)
      IDLE: begin
`ifdef JOINER_FRAMING_CHECK_EN
        if (in_pkt_valid && !in_pkt_sop) begin
          // Orphans are swallowed regardless of output backpressure.
          pkt_rdy      = 1'b1;
          stats_drop_d = stats_drop_q + 32'd1;
          if (!orphan_q) stats_err_d = stats_err_q + 32'd1;
          orphan_d     = 1'b1;
        end else
`endif
        if (in_pkt_valid && in_meta_valid && ld) begin
          pkt_rdy     = 1'b1;
          meta_rdy    = 1'b1;
          orphan_d    = 1'b0;
          out_data_d  = in_pkt_data;
          out_sop_d   = in_pkt_sop;
          out_eop_d   = in_pkt_eop;
          out_empty_d = in_pkt_empty;
          out_meta_d  = in_meta_data;
          out_valid_d = 1'b1;
          if (!in_pkt_eop) state_d = STREAM;
        end
      end
      STREAM: begin
`ifdef JOINER_FRAMING_CHECK_EN
        if (in_pkt_valid && in_pkt_sop) begin
          // Leave the new SOP waiting; CLOSE terminates the current packet first.
          stats_err_d = stats_err_q + 32'd1;
          state_d     = CLOSE;
        end else
`endif
        begin
          pkt_rdy = ld;
          if (in_pkt_valid && ld) begin
            out_data_d  = in_pkt_data;
            out_sop_d   = 1'b0;
            out_eop_d   = in_pkt_eop;
            out_empty_d = in_pkt_empty;
            out_valid_d = 1'b1;
            if (in_pkt_eop) state_d = IDLE;
          end
        end
      end
      CLOSE: begin
        if (ld) begin
          out_data_d  = '0;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b1;
          out_empty_d = EWIDTH'(DWIDTH/8 - 1);
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= '0;
      out_meta_q   <= '0;
      out_valid_q  <= 1'b0;
      orphan_q     <= 1'b0;
      stats_pkt_q  <= '0;
      stats_err_q  <= '0;
      stats_drop_q <= '0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      out_meta_q   <= out_meta_d;
      out_valid_q  <= out_valid_d;
      orphan_q     <= orphan_d;
      stats_pkt_q  <= stats_pkt_d;
      stats_err_q  <= stats_err_d;
      stats_drop_q <= stats_drop_d;
    end
  end

  assign in_pkt_ready    = pkt_rdy;
  assign in_meta_ready   = meta_rdy;
  assign out_data        = out_data_q;
  assign out_sop         = out_sop_q;
  assign out_eop         = out_eop_q;
  assign out_empty       = out_empty_q;
  assign out_meta        = out_meta_q;
  assign out_valid       = out_valid_q;
  assign stats_pkt       = stats_pkt_q;
  assign stats_err       = stats_err_q;
  assign stats_drop_flit = stats_drop_q;

endmodule

// File: tb/tb_check_pkt_meta_joiner.sv
// tb/tb_check_pkt_meta_joiner.sv - directed bench for check_pkt_meta_joiner
// Expectations follow JOINER_FRAMING_CHECK_EN when defined, the pass-through build otherwise.
module tb_check_pkt_meta_joiner;
  localparam int DW = 512;
  localparam int EW = 6;
  localparam int MW = 64;

  logic          Clk, Rst;
  logic [DW-1:0] in_pkt_data;
  logic          in_pkt_valid, in_pkt_sop, in_pkt_eop;
  logic [EW-1:0] in_pkt_empty;
  logic          in_pkt_ready;
  logic [MW-1:0] in_meta_data;
  logic          in_meta_valid, in_meta_ready;
  logic [DW-1:0] out_data;
  logic          out_sop, out_eop;
  logic [EW-1:0] out_empty;
  logic [MW-1:0] out_meta;
  logic          out_valid, out_ready;
  logic [31:0]   stats_pkt, stats_err, stats_drop_flit;

  check_pkt_meta_joiner #(.DWIDTH(DW), .EWIDTH(EW), .MWIDTH(MW)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_sop(in_pkt_sop),
    .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_meta(out_meta), .out_valid(out_valid), .out_ready(out_ready),
    .stats_pkt(stats_pkt), .stats_err(stats_err), .stats_drop_flit(stats_drop_flit)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
    logic [EW-1:0] m;
    logic [MW-1:0] meta;
    int            c;
  } beat_t;

  beat_t    q[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  bit       tog_en = 0;
  bit       stall_prev = 0;
  logic [583:0] prev_out;

  localparam logic [MW-1:0] MA = 64'hAAAA_0001;
  localparam logic [MW-1:0] MB = 64'hBBBB_0002;
  localparam logic [MW-1:0] MC = 64'hCCCC_0003;
  localparam logic [MW-1:0] MD = 64'hDDDD_0004;
  localparam logic [MW-1:0] ME = 64'hEEEE_0005;
  localparam logic [MW-1:0] MF = 64'hFFFF_0006;
  localparam logic [MW-1:0] MG = 64'h1111_0007;
  localparam logic [MW-1:0] MH = 64'h2222_0008;
  localparam logic [MW-1:0] MI = 64'h3333_0009;

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      out_ready = tog_en ? ~out_ready : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Capture accepted output beats and check hold-stability under backpressure.
  always @(negedge Clk) begin
    if (Rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev)
        chk("stall_stable", {out_data, out_sop, out_eop, out_empty, out_meta}, prev_out);
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_data, out_sop, out_eop, out_empty, out_meta};
      if (out_valid && out_ready)
        q.push_back('{d: out_data, s: out_sop, e: out_eop, m: out_empty, meta: out_meta, c: cyc});
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic s, input logic e,
                      input logic [EW-1:0] emp, input logic mv, input logic [MW-1:0] m);
    int n = 0;
    in_pkt_data   = d;
    in_pkt_sop    = s;
    in_pkt_eop    = e;
    in_pkt_empty  = emp;
    in_pkt_valid  = 1'b1;
    in_meta_valid = mv;
    in_meta_data  = m;
    forever begin
      @(negedge Clk);
      if (in_pkt_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $error("FAIL send_timeout: flit %0h never accepted", d[31:0]);
        break;
      end
    end
    @(posedge Clk);
    #1;
    in_meta_valid = 1'b0;
  endtask

  task automatic idle_in();
    in_pkt_valid  = 1'b0;
    in_meta_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge Clk);
      if (!out_valid) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $error("FAIL drain_timeout: out_valid stuck at 1");
        break;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1;
    idle_in();
    in_pkt_data  = '0;
    in_pkt_sop   = 1'b0;
    in_pkt_eop   = 1'b0;
    in_pkt_empty = '0;
    in_meta_data = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stats_pkt", stats_pkt, 0);
    chk("rst_stats_err", stats_err, 0);
    chk("rst_stats_drop", stats_drop_flit, 0);
    chk("rst_out_meta", out_meta, 0);
    chk("rst_pkt_ready", in_pkt_ready, 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // Back-to-back 3-flit packet then single-flit packet.
    q.delete();
    send(1, 1, 0, 0, 1, MA);
    send(2, 0, 0, 0, 0, 0);
    send(3, 0, 1, 5, 0, 0);
    send(4, 1, 1, 7, 1, MB);
    idle_in();
    drain();
    chk("b2b_count", q.size(), 4);
    for (int i = 0; i < q.size() && i < 4; i++) begin
      chk($sformatf("b2b_data%0d", i), q[i].d, i + 1);
      chk($sformatf("b2b_meta%0d", i), q[i].meta, (i == 3) ? MB : MA);
      chk($sformatf("b2b_sop%0d", i), q[i].s, (i == 0 || i == 3));
      chk($sformatf("b2b_eop%0d", i), q[i].e, (i >= 2));
      if (i > 0) chk($sformatf("b2b_consec%0d", i), q[i].c, q[i-1].c + 1);
    end
    if (q.size() >= 3) chk("b2b_empty2", q[2].m, 5);
    chk("b2b_stats_pkt", stats_pkt, 2);

    // Metadata valid long before the SOP flit.
    q.delete();
    in_meta_valid = 1'b1;
    in_meta_data  = MC;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk($sformatf("early_meta_rdy%0d", i), in_meta_ready, 0);
    end
    @(posedge Clk);
    #1;
    in_pkt_data  = 'h33;
    in_pkt_sop   = 1'b1;
    in_pkt_eop   = 1'b1;
    in_pkt_empty = 0;
    in_pkt_valid = 1'b1;
    @(negedge Clk);
    chk("early_meta_rdy_sop", in_meta_ready, 1);
    chk("early_pkt_rdy_sop", in_pkt_ready, 1);
    @(posedge Clk);
    #1;
    idle_in();
    drain();
    chk("early_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("early_meta", q[0].meta, MC);
      chk("early_data", q[0].d, 'h33);
    end

    // 8-flit packet with out_ready toggling each cycle.
    q.delete();
    tog_en = 1;
    for (int i = 0; i < 8; i++)
      send(DW'('h100 + i), (i == 0), (i == 7), 0, (i == 0), MD);
    idle_in();
    tog_en = 0;
    drain();
    chk("bp_count", q.size(), 8);
    for (int i = 0; i < q.size() && i < 8; i++) begin
      chk($sformatf("bp_data%0d", i), q[i].d, 'h100 + i);
      chk($sformatf("bp_meta%0d", i), q[i].meta, MD);
      chk($sformatf("bp_sop%0d", i), q[i].s, (i == 0));
    end
    chk("bp_stats_pkt", stats_pkt, 4);

`ifdef JOINER_FRAMING_CHECK_EN
    // Two orphans, then a clean packet.
    q.delete();
    send('hE0, 0, 0, 0, 0, 0);
    send('hE1, 0, 0, 0, 0, 0);
    send('h200, 1, 0, 0, 1, ME);
    send('h201, 0, 1, 0, 0, 0);
    idle_in();
    drain();
    chk("orph_drop", stats_drop_flit, 2);
    chk("orph_err", stats_err, 1);
    chk("orph_count", q.size(), 2);
    if (q.size() >= 2) begin
      chk("orph_d0", q[0].d, 'h200);
      chk("orph_s0", q[0].s, 1);
      chk("orph_m0", q[0].meta, ME);
      chk("orph_d1", q[1].d, 'h201);
      chk("orph_e1", q[1].e, 1);
    end

    // Truncated packet closed by a synthetic EOP.
    q.delete();
    send('h300, 1, 0, 0, 1, MF);
    send('h301, 0, 0, 0, 0, 0);
    send('h400, 1, 1, 0, 1, MG);
    idle_in();
    drain();
    chk("trunc_count", q.size(), 4);
    if (q.size() >= 4) begin
      chk("trunc_mid", q[1].d, 'h301);
      chk("trunc_syn_data", q[2].d, 0);
      chk("trunc_syn_eop", q[2].e, 1);
      chk("trunc_syn_sop", q[2].s, 0);
      chk("trunc_syn_empty", q[2].m, 63);
      chk("trunc_syn_meta", q[2].meta, MF);
      chk("trunc_new_data", q[3].d, 'h400);
      chk("trunc_new_sop", q[3].s, 1);
      chk("trunc_new_meta", q[3].meta, MG);
    end
    chk("trunc_err", stats_err, 2);
    chk("trunc_pkt", stats_pkt, 7);
`else
    // Non-SOP flit in IDLE is joined with metadata and keeps sop=0.
    q.delete();
    send('h200, 0, 0, 0, 1, ME);
    send('h201, 0, 1, 0, 0, 0);
    idle_in();
    drain();
    chk("nosop_count", q.size(), 2);
    if (q.size() >= 2) begin
      chk("nosop_s0", q[0].s, 0);
      chk("nosop_m0", q[0].meta, ME);
      chk("nosop_d1", q[1].d, 'h201);
    end
    chk("nosop_err", stats_err, 0);
    chk("nosop_drop", stats_drop_flit, 0);

    // SOP inside a packet is ignored; only EOP closes it.
    q.delete();
    send('h300, 1, 0, 0, 1, MF);
    send('h301, 0, 0, 0, 0, 0);
    send('h400, 1, 1, 0, 0, 0);
    idle_in();
    drain();
    chk("midsop_count", q.size(), 3);
    if (q.size() >= 3) begin
      chk("midsop_d2", q[2].d, 'h400);
      chk("midsop_s2", q[2].s, 0);
      chk("midsop_e2", q[2].e, 1);
      chk("midsop_m2", q[2].meta, MF);
    end
    chk("midsop_err", stats_err, 0);
    chk("midsop_pkt", stats_pkt, 6);
`endif

    // Reset in the middle of a packet.
    send('h500, 1, 0, 0, 1, MH);
    send('h501, 0, 0, 0, 0, 0);
    idle_in();
    Rst = 1'b1;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_stats_pkt", stats_pkt, 0);
    chk("mrst_stats_err", stats_err, 0);
    chk("mrst_stats_drop", stats_drop_flit, 0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    q.delete();
    send('h600, 1, 1, 0, 1, MI);
    idle_in();
    drain();
    chk("mrst_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("mrst_meta", q[0].meta, MI);
      chk("mrst_data", q[0].d, 'h600);
      chk("mrst_sop", q[0].s, 1);
    end
    chk("mrst_pkt", stats_pkt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/check_pkt_meta_joiner.md
# check_pkt_meta_joiner

Sits directly downstream of the reassembler's `out_pkt` and `out_meta` streams, in front of the string-matcher front end. Joins each packet's flit stream with its metadata word and emits one combined Avalon stream, with metadata held as a sideband for the whole packet. Checks SOP/EOP framing, discards orphan flits and closes truncated packets, and keeps packet and error counters for the stats path.

## Interface
Parameters:
- `DWIDTH`, 512: packet flit data width.
- `EWIDTH`, 6: empty-field width; must equal log2(DWIDTH/8).
- `MWIDTH`, `META_WIDTH`: metadata width, which is `$bits(metadata_t)`.

Ports:
- `Clk` input 1: the single clock.
- `Rst` input 1: reset. Asynchronous and active-high.
- `in_pkt_data`, `in_pkt_valid`, `in_pkt_sop`, `in_pkt_eop`, `in_pkt_empty` input DWIDTH/1/1/1/EWIDTH: packet flits from the reassembler `out_pkt`.
- `in_pkt_ready` output 1: flit accept.
- `in_meta_data`, `in_meta_valid` input MWIDTH/1: metadata from the reassembler `out_meta`.
- `in_meta_ready` output 1: metadata accept.
- `out_data`, `out_sop`, `out_eop`, `out_empty` output DWIDTH/1/1/EWIDTH: joined flits.
- `out_meta` output MWIDTH: metadata of the current packet, stable from SOP through EOP.
- `out_valid` output 1: joined flit valid.
- `out_ready` input 1: downstream accept.
- `stats_pkt` output 32: packets emitted, counted at each accepted output EOP.
- `stats_err` output 32: framing errors.
- `stats_drop_flit` output 32: discarded input flits.

## Operation
- The output is a single register stage. It can load (`ld`) when `!out_valid || out_ready`.
- The FSM has three states: IDLE, STREAM and CLOSE.

IDLE:
- `in_meta_ready = ld & in_pkt_valid & in_pkt_sop & in_meta_valid`.
- `in_pkt_ready` follows the same condition. Metadata and the SOP flit are consumed in the same cycle.
- On consume, the flit is loaded and `out_meta` is latched.
- If the consumed flit also has EOP (single-flit packet), the FSM stays in IDLE. Otherwise it goes to STREAM.
- A valid non-SOP flit in IDLE is an orphan:
  - it is consumed with `in_pkt_ready=1` and not output;
  - `stats_drop_flit` increments;
  - `stats_err` increments once per orphan run, at the first flit of the run.

STREAM:
- `in_pkt_ready = ld`. Each accepted flit is loaded with `out_sop=0`.
- An accepted flit with EOP returns the FSM to IDLE.
- `in_meta_ready=0`.
- A valid flit with SOP in STREAM marks a truncated packet:
  - the flit is not consumed;
  - `stats_err` increments;
  - the FSM goes to CLOSE.

CLOSE:
- When `ld`, emit a synthetic flit: data=0, `sop=0`, `eop=1`, `empty=DWIDTH/8-1`, with `out_meta` unchanged.
- Then go to IDLE, where the pending SOP flit is handled normally.

Common rules:
- `out_meta` changes only when an SOP flit is loaded.
- All counters are 32 bits and wrap from 0xFFFFFFFF to 0.
- Reset clears all outputs and counters to 0 and returns the FSM to IDLE. Any in-flight packet is abandoned with no EOP emitted.

## Timing
- Latency is 1 cycle from input accept to `out_valid`. Full throughput is one flit per cycle while `out_ready=1`.
- `in_pkt_ready` and `in_meta_ready` are combinational from `out_ready`, `out_valid`, the FSM state and input valids. They do not depend on their own `ready` outputs.
- While `out_valid=1 && out_ready=0`, all `out_*` signals are held stable.
- Inputs must hold data while valid and not ready. The block never consumes metadata without a SOP flit.
- The CLOSE state costs exactly one output cycle.
- Counters update on the clock edge after the counted event.

## Configuration
- `JOINER_FRAMING_CHECK_EN` defined: orphan discard, CLOSE insertion, `stats_err` and `stats_drop_flit` all operate as described above.
- Not defined:
  - In IDLE, any valid flit is paired with metadata as if it carried SOP. `out_sop` passes the input bit through.
  - In STREAM, SOP is ignored and only EOP ends the packet.
  - CLOSE is never entered.
  - `stats_err` and `stats_drop_flit` are tied to 0.
- `stats_pkt` and the datapath are identical in both builds.

## Test plan
- Back-to-back traffic: 3-flit packet with meta A, then a 1-flit (SOP+EOP) packet with meta B, `out_ready=1`.
  - Expect 4 output flits on consecutive cycles, `out_meta`=A,A,A,B, and `stats_pkt`=2.
- Metadata arrives before flits: meta valid 5 cycles before SOP.
  - Expect `in_meta_ready` held at 0 until the SOP cycle, then meta and SOP accepted together.
- Backpressure: toggle `out_ready` every cycle during an 8-flit packet.
  - Expect outputs stable while stalled, no flit lost or duplicated, and 8 flits in order.
- Orphan flits: 2 non-SOP flits in IDLE, then a valid packet.
  - Expect `stats_drop_flit`=2, `stats_err`=1, and the packet passed intact.
- Truncation: SOP flit, 1 middle flit, then a new SOP arrives.
  - Expect the synthetic flit (eop=1, empty=63, data=0), `stats_err`=1, and the new packet following with its own meta.
- Reset during STREAM: assert `Rst` for 1 cycle mid-packet.
  - Expect `out_valid`=0 and counters=0 immediately.
  - The next SOP is joined with the next meta.
